// File: rtl/axis_header_splitter.sv
// Splits each AXI-Stream packet into a fixed-length header stream and a body stream.
// Each output has a one-entry register; runt packets are flagged on the header tuser.
module axis_header_splitter #(
   parameter int DATA_WIDTH = 8,
   parameter int HDR_WORDS  = 14,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_hdr_tdata,
   output logic                  m_hdr_tvalid,
   output logic                  m_hdr_tlast,
   output logic                  m_hdr_tuser,
   input  logic                  m_hdr_tready,
   output logic [DATA_WIDTH-1:0] m_body_tdata,
   output logic                  m_body_tvalid,
   output logic                  m_body_tlast,
   input  logic                  m_body_tready,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  runt_cnt,
   output logic                  dbg_state_o
);
   // Handshake: a word moves on a port only on a cycle where its tvalid and tready are both 1.
   localparam int IDX_W = $clog2(HDR_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

   typedef enum logic {HEADER = 1'b0, BODY = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        hdr_idx_q, hdr_idx_d;
   logic [DATA_WIDTH-1:0]   hdr_data_q, body_data_q;
   logic                    hdr_valid_q, hdr_last_q, hdr_user_q;
   logic                    body_valid_q, body_last_q;
   logic [CNT_WIDTH-1:0]    pkt_cnt_q, runt_cnt_q;
   logic                    in_xfer, at_last, hdr_load, body_load;

   assign at_last  = (hdr_idx_q == LAST_IDX);
   assign s_tready = (state_q == HEADER) ? (!hdr_valid_q || m_hdr_tready)
                                         : (!body_valid_q || m_body_tready);
   assign in_xfer  = s_tvalid && s_tready;

   always_comb begin
      state_d   = state_q;
      hdr_idx_d = hdr_idx_q;
      hdr_load  = 1'b0;
      body_load = 1'b0;
      case (state_q)
         HEADER: begin
            if (in_xfer) begin
               hdr_load = 1'b1;
               if (s_tlast || at_last) hdr_idx_d = '0;
               else                    hdr_idx_d = hdr_idx_q + 1'b1;
               if (at_last && !s_tlast) state_d = BODY;
            end
         end
         BODY: begin
            if (in_xfer) begin
               body_load = 1'b1;
               if (s_tlast) state_d = HEADER;
            end
         end
         default: state_d = HEADER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HEADER;
         hdr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         hdr_idx_q <= hdr_idx_d;
      end
   end

   // A load wins over a drain, so a simultaneous drain and load keeps tvalid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_valid_q <= 1'b0;
         hdr_data_q  <= '0;
         hdr_last_q  <= 1'b0;
         hdr_user_q  <= 1'b0;
      end else if (hdr_load) begin
         hdr_valid_q <= 1'b1;
         hdr_data_q  <= s_tdata;
         hdr_last_q  <= s_tlast || at_last;
         hdr_user_q  <= s_tlast && !at_last;
      end else if (m_hdr_tready) begin
         hdr_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         body_valid_q <= 1'b0;
         body_data_q  <= '0;
         body_last_q  <= 1'b0;
      end else if (body_load) begin
         body_valid_q <= 1'b1;
         body_data_q  <= s_tdata;
         body_last_q  <= s_tlast;
      end else if (m_body_tready) begin
         body_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q  <= '0;
         runt_cnt_q <= '0;
      end else begin
         if (in_xfer && s_tlast && (pkt_cnt_q != '1))
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
         if (hdr_load && s_tlast && !at_last && (runt_cnt_q != '1))
            runt_cnt_q <= runt_cnt_q + 1'b1;
      end
   end

   assign m_hdr_tdata   = hdr_data_q;
   assign m_hdr_tvalid  = hdr_valid_q;
   assign m_hdr_tlast   = hdr_last_q;
   assign m_hdr_tuser   = hdr_user_q;
   assign m_body_tdata  = body_data_q;
   assign m_body_tvalid = body_valid_q;
   assign m_body_tlast  = body_last_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign runt_cnt      = runt_cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_header_splitter.sv
// Bench for axis_header_splitter with HDR_WORDS=4: a reference model routes accepted words
// into expected queues which a monitor drains as the DUT's output ports transfer.
module tb_axis_header_splitter;
  localparam int DW = 8;
  localparam int HW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_hdr_tdata, m_body_tdata;
  logic          m_hdr_tvalid, m_hdr_tlast, m_hdr_tuser, m_hdr_tready;
  logic          m_body_tvalid, m_body_tlast, m_body_tready;
  logic [CW-1:0] pkt_cnt, runt_cnt;
  logic          dbg_state;

  axis_header_splitter #(.DATA_WIDTH(DW), .HDR_WORDS(HW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_hdr_tdata(m_hdr_tdata), .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tlast(m_hdr_tlast),
    .m_hdr_tuser(m_hdr_tuser), .m_hdr_tready(m_hdr_tready),
    .m_body_tdata(m_body_tdata), .m_body_tvalid(m_body_tvalid), .m_body_tlast(m_body_tlast),
    .m_body_tready(m_body_tready),
    .pkt_cnt(pkt_cnt), .runt_cnt(runt_cnt), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // scoreboard: element = {tuser, tlast, tdata}; *_t holds expected monitor cycle or -1
  logic [DW+1:0] exp_hdr_q[$];
  logic [DW+1:0] exp_body_q[$];
  int            exp_hdr_t[$];
  int            exp_body_t[$];
  bit            chk_lat = 1'b0;

  // reference model state
  bit            m_in_body = 1'b0;
  int            m_idx = 0;
  int            exp_pkt = 0;
  int            exp_runt = 0;
  int            acc_cyc = 0;

  task automatic model_reset();
    m_in_body = 1'b0;
    m_idx = 0;
    exp_pkt = 0;
    exp_runt = 0;
    exp_hdr_q.delete();
    exp_hdr_t.delete();
    exp_body_q.delete();
    exp_body_t.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input bit last);
    int tag;
    bit lastidx;
    tag = chk_lat ? cyc + 1 : -1;
    if (last) exp_pkt++;
    if (!m_in_body) begin
      lastidx = (m_idx == HW - 1);
      exp_hdr_q.push_back({last && !lastidx, last || lastidx, d});
      exp_hdr_t.push_back(tag);
      if (last && !lastidx) exp_runt++;
      if (last || lastidx) m_idx = 0;
      else m_idx++;
      if (lastidx && !last) m_in_body = 1'b1;
    end else begin
      exp_body_q.push_back({1'b0, last, d});
      exp_body_t.push_back(tag);
      if (last) m_in_body = 1'b0;
    end
  endtask

  // monitor: sampled on the falling edge; a transfer happens at the next rising edge
  logic [DW+1:0] mon_e;
  int            mon_t;
  always @(negedge clk) begin
    if (!rst && m_hdr_tvalid && m_hdr_tready) begin
      total++;
      if (exp_hdr_q.size() == 0) begin
        $display("FAIL hdr_unexpected got=%h", {m_hdr_tuser, m_hdr_tlast, m_hdr_tdata});
      end else begin
        mon_e = exp_hdr_q.pop_front();
        mon_t = exp_hdr_t.pop_front();
        if ({m_hdr_tuser, m_hdr_tlast, m_hdr_tdata} !== mon_e)
          $display("FAIL hdr_word got={user,last,data}=%h exp=%h", {m_hdr_tuser, m_hdr_tlast, m_hdr_tdata}, mon_e);
        else passed++;
        if (mon_t >= 0) begin
          total++;
          if (cyc !== mon_t) $display("FAIL hdr_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_t);
          else passed++;
        end
      end
    end
    if (!rst && m_body_tvalid && m_body_tready) begin
      total++;
      if (exp_body_q.size() == 0) begin
        $display("FAIL body_unexpected got=%h", {1'b0, m_body_tlast, m_body_tdata});
      end else begin
        mon_e = exp_body_q.pop_front();
        mon_t = exp_body_t.pop_front();
        if ({1'b0, m_body_tlast, m_body_tdata} !== mon_e)
          $display("FAIL body_word got={0,last,data}=%h exp=%h", {1'b0, m_body_tlast, m_body_tdata}, mon_e);
        else passed++;
        if (mon_t >= 0) begin
          total++;
          if (cyc !== mon_t) $display("FAIL body_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_t);
          else passed++;
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send_word(input logic [DW-1:0] d, input bit last);
    int n;
    n = 0;
    s_tdata = d;
    s_tlast = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      total++;
      $display("FAIL s_tready_timeout data=%h got=0 exp=1", d);
    end else begin
      acc_cyc = cyc;
      model_accept(d, last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) send_word(base + DW'(i), i == n - 1);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    m_hdr_tready = 1'b1; m_body_tready = 1'b1;
    idle(3);
    @(negedge clk);
    total++;
    if ({m_hdr_tvalid, m_body_tvalid} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {m_hdr_tvalid, m_body_tvalid});
    else passed++;
    total++;
    if ({m_hdr_tdata, m_hdr_tlast, m_hdr_tuser, m_body_tdata, m_body_tlast} !== '0)
      $display("FAIL reset_data got=%h/%h exp=0", m_hdr_tdata, m_body_tdata);
    else passed++;
    total++;
    if ({pkt_cnt, runt_cnt} !== '0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_cnt, runt_cnt);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (s_tready !== 1'b1) $display("FAIL reset_tready got=%b exp=1", s_tready);
    else passed++;
    total++;
    if (dbg_state !== 1'b0) $display("FAIL reset_state got=%b exp=0", dbg_state);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_split();
    chk_lat = 1'b1;
    send_pkt(8'h10, 7);
    idle(4);
    total++;
    if (pkt_cnt !== CW'(1)) $display("FAIL basic_pkt_cnt got=%0d exp=1", pkt_cnt);
    else passed++;
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0)
      $display("FAIL basic_drain got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
  endtask

  task automatic test_runt();
    chk_lat = 1'b1;
    send_pkt(8'hA0, 2);
    idle(3);
    total++;
    if (runt_cnt !== CW'(1)) $display("FAIL runt_cnt got=%0d exp=1", runt_cnt);
    else passed++;
    send_pkt(8'hB0, 5);
    idle(4);
    total++;
    if ({pkt_cnt, runt_cnt} !== {CW'(exp_pkt), CW'(exp_runt)})
      $display("FAIL runt_counters got=%0d/%0d exp=%0d/%0d", pkt_cnt, runt_cnt, exp_pkt, exp_runt);
    else passed++;
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0) $display("FAIL runt_drain got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
  endtask

  task automatic test_header_only();
    chk_lat = 1'b1;
    send_pkt(8'hC0, 4);
    idle(3);
    total++;
    if (pkt_cnt !== CW'(exp_pkt)) $display("FAIL hdronly_pkt_cnt got=%0d exp=%0d", pkt_cnt, exp_pkt);
    else passed++;
    total++;
    if (dbg_state !== 1'b0) $display("FAIL hdronly_state got=%b exp=0", dbg_state);
    else passed++;
    // next packet must start as a header again
    send_pkt(8'hC8, 5);
    idle(4);
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0) $display("FAIL hdronly_drain got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
  endtask

  task automatic test_body_backpressure();
    chk_lat = 1'b0;
    m_body_tready = 1'b0;
    fork
      send_pkt(8'h50, 10);
      begin
        repeat (10) @(negedge clk);
        total++;
        if ({s_tready, m_hdr_tvalid, m_body_tvalid, m_body_tdata} !== {1'b0, 1'b0, 1'b1, 8'h54})
          $display("FAIL bp_stall got={rdy,hv,bv,bd}=%b%b%b_%h exp=001_54", s_tready, m_hdr_tvalid, m_body_tvalid, m_body_tdata);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({m_body_tvalid, m_body_tlast, m_body_tdata} !== {1'b1, 1'b0, 8'h54})
          $display("FAIL bp_hold got=%b%b_%h exp=10_54", m_body_tvalid, m_body_tlast, m_body_tdata);
        else passed++;
        @(posedge clk); #1;
        m_body_tready = 1'b1;
      end
    join
    idle(4);
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0) $display("FAIL bp_lost got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
    total++;
    if (pkt_cnt !== CW'(exp_pkt)) $display("FAIL bp_pkt_cnt got=%0d exp=%0d", pkt_cnt, exp_pkt);
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    chk_lat = 1'b1;
    send_word(8'h30, 1'b0);
    send_word(8'h31, 1'b0);
    send_word(8'h32, 1'b0);
    m_hdr_tready = 1'b0;
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({m_hdr_tvalid, m_body_tvalid, pkt_cnt, runt_cnt} !== '0)
      $display("FAIL midrst_clear got=%b%b cnt=%0d/%0d exp=00 0/0", m_hdr_tvalid, m_body_tvalid, pkt_cnt, runt_cnt);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (s_tready !== 1'b1) $display("FAIL midrst_tready got=%b exp=1", s_tready);
    else passed++;
    @(posedge clk); #1;
    m_hdr_tready = 1'b1;
    send_pkt(8'h60, 6);
    idle(4);
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0) $display("FAIL midrst_drain got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
    total++;
    if (pkt_cnt !== CW'(1)) $display("FAIL midrst_pkt_cnt got=%0d exp=1", pkt_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lens[5];
    int first_cyc, nwords;
    lens = '{5, 3, 6, 4, 1};
    chk_lat = 1'b1;
    nwords = 0;
    first_cyc = -1;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        send_word(DW'($urandom_range(0, 255)), i == lens[p] - 1);
        if (first_cyc < 0) first_cyc = acc_cyc;
        nwords++;
      end
    end
    s_tvalid = 1'b0;
    total++;
    if (acc_cyc - first_cyc !== nwords - 1) $display("FAIL b2b_rate got=%0d exp=%0d", acc_cyc - first_cyc, nwords - 1);
    else passed++;
    idle(4);
    total++;
    if ({pkt_cnt, runt_cnt} !== {CW'(exp_pkt), CW'(exp_runt)})
      $display("FAIL b2b_counters got=%0d/%0d exp=%0d/%0d", pkt_cnt, runt_cnt, exp_pkt, exp_runt);
    else passed++;
  endtask

  task automatic test_random_ready();
    bit done;
    done = 1'b0;
    chk_lat = 1'b0;
    fork
      begin
        for (int p = 0; p < 12; p++) send_pkt(DW'($urandom_range(0, 255)), $urandom_range(1, 9));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_hdr_tready = ($urandom_range(0, 3) != 0);
          m_body_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    m_hdr_tready = 1'b1;
    m_body_tready = 1'b1;
    idle(5);
    total++;
    if (exp_hdr_q.size() + exp_body_q.size() != 0) $display("FAIL rand_drain got=%0d exp=0", exp_hdr_q.size() + exp_body_q.size());
    else passed++;
    total++;
    if ({pkt_cnt, runt_cnt} !== {CW'(exp_pkt), CW'(exp_runt)})
      $display("FAIL rand_counters got=%0d/%0d exp=%0d/%0d", pkt_cnt, runt_cnt, exp_pkt, exp_runt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_split();
    test_runt();
    test_header_only();
    test_body_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    test_random_ready();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_header_splitter.md
AXIS_HEADER_SPLITTER -- requirements
Module: axis_header_splitter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every tdata bus in bits.
REQ-002 Parameter HDR_WORDS, default 14, number of input words per packet routed to the header port; the legal range is >= 2.
REQ-003 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_tdata  input  DATA_WIDTH  merged packet stream data.
REQ-007 s_tvalid  input  1  input word valid.
REQ-008 s_tlast  input  1  last word of the input packet.
REQ-009 s_tready  output  1  block accepts the input word.
REQ-010 m_hdr_tdata  output  DATA_WIDTH  header stream data.
REQ-011 m_hdr_tvalid  output  1  header word valid.
REQ-012 m_hdr_tlast  output  1  last header word of the packet.
REQ-013 m_hdr_tuser  output  1  runt flag, qualified by m_hdr_tvalid && m_hdr_tlast.
REQ-014 m_hdr_tready  input  1  header consumer ready.
REQ-015 m_body_tdata  output  DATA_WIDTH  body stream data.
REQ-016 m_body_tvalid  output  1  body word valid.
REQ-017 m_body_tlast  output  1  last body word of the packet.
REQ-018 m_body_tready  input  1  body consumer ready.
REQ-019 pkt_cnt  output  CNT_WIDTH  count of complete input packets.
REQ-020 runt_cnt  output  CNT_WIDTH  count of runt packets.

Function
REQ-021 The block SHALL split each input packet into its first HDR_WORDS words, sent on the header port, and the remaining words, sent on the body port.
REQ-022 A transfer on any port SHALL occur only on a cycle where that port's tvalid and tready are both 1.
REQ-023 The FSM SHALL have two states: HEADER routes input to the header port and BODY routes input to the body port.
- Reset state is HEADER.
REQ-024 A word index counter (hdr_idx) SHALL count from 0 and increment on each input transfer made in HEADER.
REQ-025 In HEADER, an input transfer with hdr_idx == HDR_WORDS-1 and s_tlast=0 SHALL:
- set the header output tlast=1 and tuser=0;
- clear hdr_idx;
- move the FSM to BODY.
REQ-026 In HEADER, an input transfer with s_tlast=1 and hdr_idx < HDR_WORDS-1 (a runt) SHALL:
- set the header output tlast=1 and tuser=1;
- increment runt_cnt;
- clear hdr_idx;
- keep the FSM in HEADER;
- emit nothing on the body port.
REQ-027 In HEADER, an input transfer with s_tlast=1 and hdr_idx == HDR_WORDS-1 (header-only packet) SHALL:
- set the header output tlast=1 and tuser=0;
- clear hdr_idx;
- keep the FSM in HEADER;
- emit nothing on the body port.
REQ-028 In BODY, each input transfer SHALL go to the body port with tlast = s_tlast, and s_tlast=1 SHALL return the FSM to HEADER.
REQ-029 In HEADER, every header output word other than those in REQ-025/026/027 SHALL have tlast=0 and tuser=0.
REQ-030 Each output port SHALL have a one-entry output register; data, tlast and tuser are captured on the accepting input transfer, giving a latency of exactly 1 cycle from input transfer to output tvalid.
REQ-031 s_tready SHALL be (!m_hdr_tvalid || m_hdr_tready) in HEADER and (!m_body_tvalid || m_body_tready) in BODY, computed combinationally.
REQ-032 An output register SHALL clear tvalid when its word is transferred out and no new word loads on that cycle; a simultaneous drain and load SHALL keep tvalid=1 with the new word.
REQ-033 Output tvalid, tdata, tlast and tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-034 Backpressure on the inactive port SHALL NOT stall the active port.
REQ-035 pkt_cnt SHALL increment on every input transfer with s_tlast=1, including runts.
REQ-036 Both counters SHALL saturate at all-ones and never wrap.
REQ-037 s_tvalid=0 in either state SHALL hold the state, hdr_idx and the output registers, except for draining per REQ-032.

Reset
REQ-038 With rst=1 at a clock edge, the block SHALL set the FSM to HEADER, hdr_idx=0, m_hdr_tvalid=0, m_body_tvalid=0, pkt_cnt=0 and runt_cnt=0.
REQ-039 Output tdata, tlast and tuser SHALL reset to 0.
REQ-040 Reset asserted mid-packet SHALL discard any partial packet and all buffered words; the first transfer after reset is treated as header word 0.
REQ-041 s_tready SHALL be 1 in the cycle after reset is released.

Verification
REQ-042 The bench SHALL cover the following scenarios, using HDR_WORDS=4 and DATA_WIDTH=8:
- A 7-word packet 0x10..0x16 with both readies held at 1 -> header port outputs 0x10..0x13 with tlast on 0x13 and tuser=0; body port outputs 0x14..0x16 with tlast on 0x16; pkt_cnt=1; each output appears 1 cycle after its input.
- A 2-word runt 0xA0,0xA1 -> header port outputs 0xA0, 0xA1 with tlast=1 and tuser=1; no body words; runt_cnt=1; the next packet's first word goes to the header port.
- A 4-word packet (header only) -> header port outputs all 4 words, tlast on word 4, tuser=0; body port stays idle; pkt_cnt increments.
- m_body_tready=0 during a 10-word packet -> s_tready drops after the first body word is registered; the header completes; releasing tready delivers the 6 body words in order with none lost.
- rst pulsed after header word 2 of a packet -> both tvalids=0 and the counters=0; a new 6-word packet then splits 4+2.
- Back-to-back packets with s_tvalid held at 1 and both readies at 1 -> the input sustains 1 word per cycle with no bubble at packet boundaries.
